// File: rtl/axi_lite_read_slave.sv
// -----------------------------------------------------------------------------
// axi_lite_read_slave
//
// AXI4-Lite read-only slave in front of an 8 x 32-bit register bank. The bank
// is written from a local strobe interface. It is read over the AR/R channels
// with a fixed, parameterised latency between address accept and RVALID. Only
// one read is outstanding at a time. Misaligned, out-of-window and (optionally)
// unprivileged reads complete with SLVERR and zero data. SLVERR responses are
// counted.
//
// Parameters
//   BASE_ADDR  : byte address of register 0 (register n lives at BASE_ADDR+4n)
//   RD_LAT     : extra wait cycles (0-15) between AR accept and RVALID
//   PROT_CHECK : 1 = reject reads with ARPROT[0]=0 (unprivileged)
//
// Ports
//   ACLK     in   clock, rising edge
//   ARESETn  in   synchronous reset, ACTIVE-HIGH despite the name
//   ARVALID  in   read address valid
//   ARREADY  out  slave accepts the address (registered, high only in IDLE)
//   ARADDR   in   [31:0] read byte address
//   ARPROT   in   [2:0] protection, bit 0 = privileged
//   RVALID   out  read data valid
//   RREADY   in   master accepts read data
//   RDATA    out  [31:0] read data
//   RRESP    out  [1:0] 2'b00 OKAY, 2'b10 SLVERR
//   wr_en    in   local register-bank write strobe
//   wr_idx   in   [2:0] local write index
//   wr_data  in   [31:0] local write data
//   err_cnt  out  [15:0] saturating count of SLVERR R handshakes
// -----------------------------------------------------------------------------
module axi_lite_read_slave #(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter int unsigned RD_LAT     = 1,
  parameter int unsigned PROT_CHECK = 0
) (
  input  logic        ACLK,
  input  logic        ARESETn,
  input  logic        ARVALID,
  output logic        ARREADY,
  input  logic [31:0] ARADDR,
  input  logic [2:0]  ARPROT,
  output logic        RVALID,
  input  logic        RREADY,
  output logic [31:0] RDATA,
  output logic [1:0]  RRESP,
  input  logic        wr_en,
  input  logic [2:0]  wr_idx,
  input  logic [31:0] wr_data,
  output logic [15:0] err_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Counter preload for the WAIT state; meaningless (and unused) when RD_LAT=0.
  localparam logic [3:0] LAT_LOAD = (RD_LAT > 0) ? 4'(RD_LAT - 1) : 4'd0;

  state_t      state;
  logic [3:0]  cnt;
  logic [31:0] ar_addr;
  logic        ar_priv;

  logic [31:0] bank [8];

  // ---------------------------------------------------------------------------
  // Register bank
  // ---------------------------------------------------------------------------
  // NOTE: the bank is reset explicitly because reset-to-zero contents are part
  // of the visible behaviour; this keeps it in flops rather than a RAM macro.
  always_ff @(posedge ACLK) begin
    if (ARESETn) begin
      for (int i = 0; i < 8; i++) begin
        bank[i] <= '0;
      end
    end else if (wr_en) begin
      bank[wr_idx] <= wr_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  // In IDLE the decode looks at the live AR bus so that RD_LAT=0 can respond on
  // the handshake edge itself; afterwards it uses the latched address.
  logic [31:0] rd_addr;
  logic        rd_priv;
  logic [32:0] rd_diff;
  logic        rd_ok;
  logic [31:0] rd_word;
  logic [1:0]  rd_resp;

  // NOTE: every always_comb output gets a default first so that no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    rd_addr = ar_addr;
    rd_priv = ar_priv;
    if (state == IDLE) begin
      rd_addr = ARADDR;
      rd_priv = ARPROT[0];
    end
    // 33-bit difference: bit 32 set means the address lies below BASE_ADDR,
    // so the window test cannot wrap around the top of the address space.
    rd_diff = {1'b0, rd_addr} - {1'b0, BASE_ADDR};
    rd_ok   = (rd_diff[32:5] == '0) && (rd_addr[1:0] == 2'b00) &&
              ((PROT_CHECK == 0) || rd_priv);
    rd_word = '0;
    rd_resp = RESP_SLVERR;
    if (rd_ok) begin
      rd_word = bank[rd_diff[4:2]];
      rd_resp = RESP_OKAY;
    end
  end

  // ARPROT[2:1] and the byte-offset bits of the difference carry no meaning.
  logic unused_bits;
  assign unused_bits = ^{ARPROT[2:1], rd_diff[1:0]};

  // ---------------------------------------------------------------------------
  // Read FSM with registered outputs
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, so every read in
  // this block sees pre-edge values; this is also what gives the bank its
  // read-before-write behaviour against a same-edge local write.
  always_ff @(posedge ACLK) begin
    if (ARESETn) begin
      state   <= IDLE;
      cnt     <= '0;
      ar_addr <= '0;
      ar_priv <= 1'b0;
      ARREADY <= 1'b0;
      RVALID  <= 1'b0;
      RDATA   <= '0;
      RRESP   <= RESP_OKAY;
      err_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          // ARREADY is low only on the first cycle after reset; it rises here.
          ARREADY <= 1'b1;
          if (ARREADY && ARVALID) begin
            ARREADY <= 1'b0;
            ar_addr <= ARADDR;
            ar_priv <= ARPROT[0];
            if (RD_LAT == 0) begin
              state  <= RESP;
              RVALID <= 1'b1;
              RDATA  <= rd_word;
              RRESP  <= rd_resp;
            end else begin
              state <= WAIT;
              cnt   <= LAT_LOAD;
            end
          end
        end

        WAIT: begin
          if (cnt == 4'd0) begin
            state  <= RESP;
            RVALID <= 1'b1;
            RDATA  <= rd_word;
            RRESP  <= rd_resp;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end

        RESP: begin
          // RDATA/RRESP simply hold until the R handshake.
          if (RREADY) begin
            RVALID  <= 1'b0;
            ARREADY <= 1'b1;
            state   <= IDLE;
            if ((RRESP == RESP_SLVERR) && (err_cnt != 16'hFFFF)) begin
              err_cnt <= err_cnt + 16'd1;
            end
          end
        end

        default: begin
          state   <= IDLE;
          RVALID  <= 1'b0;
          ARREADY <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axi_lite_read_slave.sv
// -----------------------------------------------------------------------------
// tb_axi_lite_read_slave
//
// Three instances of axi_lite_read_slave with different parameter sets share
// the AR address/prot bus and the local write port; each has its own
// handshake signals, and only one is addressed at a time. A reference model
// (register array, per-instance error count, latency from RD_LAT) predicts
// every response.
//   dut 0 : BASE 0x0000_1000, RD_LAT 1, PROT_CHECK 1
//   dut 1 : BASE 0x0000_0000, RD_LAT 0, PROT_CHECK 0
//   dut 2 : BASE 0xFFFF_FFE0, RD_LAT 4, PROT_CHECK 0
// -----------------------------------------------------------------------------
module tb_axi_lite_read_slave;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  arvalid;
  logic [2:0]  arready;
  logic [2:0]  rvalid;
  logic [2:0]  rready;
  logic [31:0] araddr;
  logic [2:0]  arprot;
  logic [31:0] rdata   [3];
  logic [1:0]  rresp   [3];
  logic [15:0] err_cnt [3];
  logic        wr_en;
  logic [2:0]  wr_idx;
  logic [31:0] wr_data;

  int total = 0;
  int bad   = 0;

  logic [31:0] mbank [8];
  int          merr  [3];

  always #5 clk = ~clk;

  axi_lite_read_slave #(.BASE_ADDR(32'h0000_1000), .RD_LAT(1), .PROT_CHECK(1)) dut0 (
    .ACLK(clk), .ARESETn(rst), .ARVALID(arvalid[0]), .ARREADY(arready[0]),
    .ARADDR(araddr), .ARPROT(arprot), .RVALID(rvalid[0]), .RREADY(rready[0]),
    .RDATA(rdata[0]), .RRESP(rresp[0]), .wr_en(wr_en), .wr_idx(wr_idx),
    .wr_data(wr_data), .err_cnt(err_cnt[0]));

  axi_lite_read_slave #(.BASE_ADDR(32'h0000_0000), .RD_LAT(0), .PROT_CHECK(0)) dut1 (
    .ACLK(clk), .ARESETn(rst), .ARVALID(arvalid[1]), .ARREADY(arready[1]),
    .ARADDR(araddr), .ARPROT(arprot), .RVALID(rvalid[1]), .RREADY(rready[1]),
    .RDATA(rdata[1]), .RRESP(rresp[1]), .wr_en(wr_en), .wr_idx(wr_idx),
    .wr_data(wr_data), .err_cnt(err_cnt[1]));

  axi_lite_read_slave #(.BASE_ADDR(32'hFFFF_FFE0), .RD_LAT(4), .PROT_CHECK(0)) dut2 (
    .ACLK(clk), .ARESETn(rst), .ARVALID(arvalid[2]), .ARREADY(arready[2]),
    .ARADDR(araddr), .ARPROT(arprot), .RVALID(rvalid[2]), .RREADY(rready[2]),
    .RDATA(rdata[2]), .RRESP(rresp[2]), .wr_en(wr_en), .wr_idx(wr_idx),
    .wr_data(wr_data), .err_cnt(err_cnt[2]));

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  function automatic logic [31:0] base_of(int s);
    case (s)
      0:       return 32'h0000_1000;
      1:       return 32'h0000_0000;
      default: return 32'hFFFF_FFE0;
    endcase
  endfunction

  function automatic int lat_of(int s);
    case (s)
      0:       return 1;
      1:       return 0;
      default: return 4;
    endcase
  endfunction

  // Offset in plain signed arithmetic: anything outside [0,32), not a multiple
  // of four, or unprivileged on the protected instance is an error.
  function automatic bit addr_ok(int s, logic [31:0] addr, logic [2:0] prot);
    longint off;
    off = longint'(addr) - longint'(base_of(s));
    if (off < 0 || off >= 32) return 1'b0;
    if (off % 4 != 0) return 1'b0;
    if (s == 0 && prot[0] == 1'b0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int idx_of(int s, logic [31:0] addr);
    longint off;
    off = longint'(addr) - longint'(base_of(s));
    return int'(off / 4);
  endfunction

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  task automatic chk(string tag, logic [31:0] observed, logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) mbank[i] = '0;
    for (int i = 0; i < 3; i++) merr[i] = 0;
  endtask

  task automatic local_write(int idx, logic [31:0] data);
    wr_en   = 1'b1;
    wr_idx  = 3'(idx);
    wr_data = data;
    tick();
    wr_en   = 1'b0;
    mbank[idx] = data;
  endtask

  // One complete read on instance s. stall = cycles RREADY is held low once
  // RVALID is seen. lw = issue a local write to the addressed register on the
  // cycle right after the AR handshake (the edge entering RESP when RD_LAT=1).
  task automatic read_txn(int s, logic [31:0] addr, logic [2:0] prot, int stall,
                          bit lw, logic [31:0] lw_data, string tag);
    logic [31:0] exp_data;
    logic [1:0]  exp_resp;
    bit          ok;
    int          n;

    ok       = addr_ok(s, addr, prot);
    exp_data = ok ? mbank[idx_of(s, addr)] : 32'h0;
    exp_resp = ok ? 2'b00 : 2'b10;

    araddr     = addr;
    arprot     = prot;
    arvalid[s] = 1'b1;
    n = 0;
    while (arready[s] !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_arready"}, 32'(arready[s]), 32'd1);
    tick();
    arvalid[s] = 1'b0;
    araddr     = $urandom;
    arprot     = 3'($urandom);
    if (lw) begin
      wr_en   = 1'b1;
      wr_idx  = 3'(idx_of(s, addr));
      wr_data = lw_data;
    end

    n = 0;
    while (rvalid[s] !== 1'b1 && n < 20) begin
      rready[s] = 1'($urandom_range(0, 1));
      tick();
      wr_en = 1'b0;
      n++;
    end
    wr_en = 1'b0;
    if (lw) mbank[idx_of(s, addr)] = lw_data;

    rready[s] = (stall == 0);
    chk({tag, "_latency"}, 32'(n + 1), 32'(1 + lat_of(s)));
    chk({tag, "_arready_busy"}, 32'(arready[s]), 32'd0);
    chk({tag, "_rdata"}, rdata[s], exp_data);
    chk({tag, "_rresp"}, 32'(rresp[s]), 32'(exp_resp));

    for (int i = 0; i < stall; i++) begin
      tick();
      chk({tag, "_hold_rvalid"}, 32'(rvalid[s]), 32'd1);
      chk({tag, "_hold_rdata"}, rdata[s], exp_data);
      chk({tag, "_hold_rresp"}, 32'(rresp[s]), 32'(exp_resp));
      chk({tag, "_hold_arready"}, 32'(arready[s]), 32'd0);
    end
    rready[s] = 1'b1;
    tick();
    rready[s] = 1'b0;
    if (!ok) merr[s]++;
    chk({tag, "_rvalid_drop"}, 32'(rvalid[s]), 32'd0);
    chk({tag, "_arready_back"}, 32'(arready[s]), 32'd1);
    chk({tag, "_err_cnt"}, 32'(err_cnt[s]), 32'(merr[s]));
  endtask

  // ---------------------------------------------------------------------------
  // Directed and random sequence
  // ---------------------------------------------------------------------------
  initial begin
    logic [31:0] a;
    int          s;
    int          off;

    rst     = 1'b1;
    arvalid = '0;
    rready  = '0;
    araddr  = '0;
    arprot  = '0;
    wr_en   = 1'b0;
    wr_idx  = '0;
    wr_data = '0;
    model_reset();

    // Reset state
    tick();
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("rst_arready", 32'(arready[i]), 32'd0);
      chk("rst_rvalid", 32'(rvalid[i]), 32'd0);
      chk("rst_rdata", rdata[i], 32'd0);
      chk("rst_rresp", 32'(rresp[i]), 32'd0);
      chk("rst_err_cnt", 32'(err_cnt[i]), 32'd0);
    end
    rst = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) chk("rel_arready", 32'(arready[i]), 32'd1);

    // Bank comes out of reset cleared
    read_txn(1, 32'h0000_0014, 3'b000, 0, 1'b0, '0, "bank_rst");

    // Basic read with RD_LAT=1
    local_write(3, 32'hDEAD_BEEF);
    read_txn(0, 32'h0000_100C, 3'b001, 0, 1'b0, '0, "basic");

    // Out of range and misaligned
    read_txn(0, 32'h0000_1020, 3'b001, 0, 1'b0, '0, "oor");
    read_txn(0, 32'h0000_1006, 3'b001, 0, 1'b0, '0, "misalign");
    chk("err_cnt_two", 32'(err_cnt[0]), 32'd2);
    read_txn(0, 32'h0000_0FFC, 3'b001, 0, 1'b0, '0, "below_base");

    // Backpressure
    read_txn(0, 32'h0000_100C, 3'b001, 5, 1'b0, '0, "stall");

    // Read-before-write on the edge entering RESP
    local_write(2, 32'h1111_2222);
    read_txn(0, 32'h0000_1008, 3'b001, 0, 1'b1, 32'h3333_4444, "rbw_old");
    read_txn(0, 32'h0000_1008, 3'b001, 0, 1'b0, '0, "rbw_new");

    // Protection
    read_txn(0, 32'h0000_100C, 3'b000, 0, 1'b0, '0, "prot_unpriv");
    read_txn(0, 32'h0000_100C, 3'b001, 0, 1'b0, '0, "prot_priv");

    // Top-of-address-space window and zero latency paths
    read_txn(2, 32'hFFFF_FFFC, 3'b000, 2, 1'b0, '0, "top_last");
    read_txn(2, 32'h0000_0000, 3'b000, 0, 1'b0, '0, "top_wrap");
    read_txn(1, 32'h0000_000C, 3'b000, 1, 1'b0, '0, "lat0");

    // Reset during WAIT aborts the read
    araddr     = 32'hFFFF_FFE4;
    arprot     = 3'b000;
    arvalid[2] = 1'b1;
    tick();
    arvalid[2] = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    chk("abort_rvalid_in_rst", 32'(rvalid[2]), 32'd0);
    rst = 1'b0;
    model_reset();
    tick();
    chk("abort_arready", 32'(arready[2]), 32'd1);
    chk("abort_err_cnt", 32'(err_cnt[2]), 32'd0);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("abort_no_rvalid", 32'(rvalid[2]), 32'd0);
    end
    read_txn(0, 32'h0000_100C, 3'b001, 0, 1'b0, '0, "post_abort");

    // Randomized traffic against the model
    for (int t = 0; t < 60; t++) begin
      if ($urandom_range(0, 2) == 0) begin
        local_write(int'($urandom_range(0, 7)), $urandom);
      end
      s   = int'($urandom_range(0, 2));
      off = int'($urandom_range(0, 47)) - 8;
      a   = base_of(s) + 32'(off);
      read_txn(s, a, 3'($urandom), int'($urandom_range(0, 3)), 1'b0, '0, "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: observed=running expected=finished");
    $fatal(1, "simulation time limit reached");
  end

endmodule
